// File: rtl/axi_stream_tx_pkg.sv
// axi_stream_tx_pkg: shared types and sizing helpers for the AXI4-Stream transmitter.
package axi_stream_tx_pkg;
    typedef enum logic {IDLE, IN_PKT} state_t;
    function automatic int entry_width(input int data_width);
        return data_width + 1;
    endfunction
    // One extra pointer bit distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/axi_stream_tx_if.sv
// axi_stream_tx_if: write port and AXI4-Stream master bundle.
interface axi_stream_tx_if #(parameter int DATA_WIDTH = 32);
    logic wr_valid, wr_ready, wr_last, tlast, tvalid, tready;
    logic [DATA_WIDTH-1:0] wr_data, tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    modport master (input wr_valid, wr_data, wr_last, tready, output wr_ready, tdata, tkeep, tlast, tvalid);
    modport slave (output wr_valid, wr_data, wr_last, tready, input wr_ready, tdata, tkeep, tlast, tvalid);
endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: synchronous FIFO with wrap-bit pointers and level output.
module axis_sync_fifo import axi_stream_tx_pkg::*; #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        wr_en,
    input  logic                        rd_en,
    input  logic [WIDTH-1:0]            wr_data,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        full,
    output logic                        empty,
    output logic [ptr_width(DEPTH)-1:0] level
);
    localparam int PW = ptr_width(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    assign full = wp == {~rp[PW-1], rp[PW-2:0]};
    assign empty = wp == rp;
    assign level = wp - rp;
    assign rd_data = mem[rp[PW-2:0]];
    always_ff @(posedge aclk)
        if (areset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_en && !full) wp <= wp + PW'(1);
            if (rd_en && !empty) rp <= rp + PW'(1);
        end
    always_ff @(posedge aclk)
        if (wr_en && !full) mem[wp[PW-2:0]] <= wr_data;
endmodule

// File: rtl/axi_stream_tx.sv
// axi_stream_tx: buffered AXI4-Stream master with packet FSM and beat/packet counters.
// Store-and-forward gating and err_oversize are enabled by AXI_STREAM_TX_STORE_FWD_EN.
module axi_stream_tx import axi_stream_tx_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             aclk,
    input  logic                             areset,
    axi_stream_tx_if.master                  s,
    output logic                             busy,
    output logic [ptr_width(FIFO_DEPTH)-1:0] fifo_level,
    output logic [CNT_WIDTH-1:0]             pkt_count,
    output logic [CNT_WIDTH-1:0]             word_count
`ifdef AXI_STREAM_TX_STORE_FWD_EN
    ,
    output logic                             err_oversize
`endif
);
    localparam int EW = entry_width(DATA_WIDTH);
    state_t state;
    logic full, empty, gate, pop, xfer, wr_en;
    logic [EW-1:0] head;
    assign wr_en = s.wr_valid && !full;
    assign s.wr_ready = !full;
    assign s.tkeep = '1;
    assign xfer = s.tvalid && s.tready;
    assign pop = (!s.tvalid || s.tready) && !empty && gate;
    assign busy = state == IN_PKT;
    axis_sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .aclk(aclk),
        .areset(areset),
        .wr_en(wr_en),
        .rd_en(pop),
        .wr_data({s.wr_last, s.wr_data}),
        .rd_data(head),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );
`ifdef AXI_STREAM_TX_STORE_FWD_EN
    localparam int PW = ptr_width(FIFO_DEPTH);
    logic [PW-1:0] pkts_held;
    logic rel_q, stuck;
    // A full FIFO with no complete packet can never finish on its own, so let it drain.
    assign stuck = full && pkts_held == '0;
    assign gate = state == IN_PKT || pkts_held != '0 || rel_q || stuck;
    always_ff @(posedge aclk)
        if (areset) begin
            pkts_held <= '0;
            rel_q <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            pkts_held <= pkts_held + PW'(wr_en && s.wr_last) - PW'(pop && head[EW-1]);
            rel_q <= stuck || (rel_q && !(pop && head[EW-1]));
            if (stuck) err_oversize <= 1'b1;
        end
`else
    assign gate = 1'b1;
`endif
    always_ff @(posedge aclk)
        if (areset) begin
            s.tvalid <= 1'b0;
            s.tdata <= '0;
            s.tlast <= 1'b0;
            state <= IDLE;
            pkt_count <= '0;
            word_count <= '0;
        end else begin
            if (pop) {s.tlast, s.tdata} <= head;
            s.tvalid <= pop || (s.tvalid && !s.tready);
            if (xfer) begin
                word_count <= word_count + CNT_WIDTH'(1);
                pkt_count <= pkt_count + CNT_WIDTH'(s.tlast);
                state <= s.tlast ? IDLE : IN_PKT;
            end
        end
endmodule

// File: tb/tb_axi_stream_tx.sv
// tb_axi_stream_tx: directed and randomised-backpressure checks of axi_stream_tx.
module tb_axi_stream_tx;
    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic busy;
    logic [4:0] fifo_level;
    logic [31:0] pkt_count, word_count;
`ifdef AXI_STREAM_TX_STORE_FWD_EN
    logic err_oversize;
`endif
    int checks = 0;
    int errors = 0;
    logic [32:0] q [$];
    logic hold = 1'b0;
    logic [32:0] held;

    axi_stream_tx_if #(.DATA_WIDTH(32)) s ();
    axi_stream_tx #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .CNT_WIDTH(32)) dut (
        .aclk(aclk),
        .areset(areset),
        .s(s),
        .busy(busy),
        .fifo_level(fifo_level),
        .pkt_count(pkt_count),
        .word_count(word_count)
`ifdef AXI_STREAM_TX_STORE_FWD_EN
        ,
        .err_oversize(err_oversize)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic put(input logic [31:0] d, input logic l);
        s.wr_valid = 1'b1;
        s.wr_data = d;
        s.wr_last = l;
    endtask

    task automatic pulse_reset();
        s.wr_valid = 1'b0;
        areset = 1'b1;
        tick();
        areset = 1'b0;
    endtask

    task automatic send(input logic [31:0] base, input int n, input int plen, input bit rnd);
        int i = 0;
        int guard = 0;
        logic acc;
        while (i < n && guard < 5000) begin
            put(base + i, (i % plen == plen - 1) || i == n - 1);
            if (rnd) s.tready = 1'($urandom_range(0, 1));
            acc = s.wr_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        s.wr_valid = 1'b0;
        check("send_timeout", 64'(guard < 5000), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        s.tready = 1'b1;
        while ((s.tvalid || fifo_level != 0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_timeout", 64'(n < 200), 64'd1);
        check("drain_queue_empty", 64'(q.size()), 64'd0);
    endtask

    // Scoreboard: mid-cycle view of what the next rising edge will transfer.
    always @(negedge aclk) begin
        if (areset) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) check("stable", {s.tvalid, s.tlast, s.tdata}, {1'b1, held});
            if (s.tvalid && s.tready) begin
                if (q.size() == 0) check("beat_unexpected", 64'(q.size()), 64'd1);
                else check("beat_order", {s.tlast, s.tdata}, q.pop_front());
            end
            if (s.wr_valid && s.wr_ready) q.push_back({s.wr_last, s.wr_data});
            hold = s.tvalid && !s.tready;
            held = {s.tlast, s.tdata};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s.wr_valid = 1'b0;
        s.wr_data = '0;
        s.wr_last = 1'b0;
        s.tready = 1'b0;
        tick();
        tick();
        areset = 1'b0;
        tick();
        check("rst_tvalid", s.tvalid, 0);
        check("rst_wr_ready", s.wr_ready, 1);
        check("rst_level", fifo_level, 0);
        check("rst_pkt", pkt_count, 0);
        check("rst_word", word_count, 0);
        check("rst_busy", busy, 0);
        check("tkeep", s.tkeep, 64'hF);
`ifndef AXI_STREAM_TX_STORE_FWD_EN
        s.tready = 1'b1;
        put(32'hA0, 0); tick();
        check("a_lat_tvalid", s.tvalid, 0);
        check("a_lat_level", fifo_level, 1);
        put(32'hA1, 0); tick();
        check("a0", {s.tvalid, s.tlast, s.tdata}, {2'b10, 32'hA0});
        put(32'hA2, 0); tick();
        check("a1", {s.tvalid, s.tlast, s.tdata}, {2'b10, 32'hA1});
        put(32'hA3, 1); tick();
        check("a2", {s.tvalid, s.tlast, s.tdata}, {2'b10, 32'hA2});
        s.wr_valid = 1'b0; tick();
        check("a3", {s.tvalid, s.tlast, s.tdata}, {2'b11, 32'hA3});
        check("a_busy", busy, 1);
        tick();
        check("a_end_tvalid", s.tvalid, 0);
        check("a_pkt", pkt_count, 1);
        check("a_word", word_count, 4);
        check("a_idle", busy, 0);
        s.tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            put(32'hB00 + i, 0);
            tick();
        end
        check("b_level15", fifo_level, 15);
        check("b_ready_before_full", s.wr_ready, 1);
        put(32'hB10, 1); tick();
        s.wr_valid = 1'b0;
        check("b_level16", fifo_level, 16);
        check("b_full", s.wr_ready, 0);
        check("b_hold", {s.tvalid, s.tdata}, {1'b1, 32'hB00});
        tick();
        check("b_still_full", s.wr_ready, 0);
        s.tready = 1'b1; tick();
        check("b_ready_back", s.wr_ready, 1);
        check("b_level_pop", fifo_level, 15);
        check("b_next", s.tdata, 32'hB01);
        drain();
        check("b_word", word_count, 21);
        check("b_pkt", pkt_count, 2);
`endif
        pulse_reset();
        check("r_word", word_count, 0);
        send(32'hC000, 200, 7, 1);
        drain();
        check("c_word", word_count, 200);
        check("c_pkt", pkt_count, 29);
        check("c_busy", busy, 0);
`ifndef AXI_STREAM_TX_STORE_FWD_EN
        s.tready = 1'b1;
        put(32'hD0, 0); tick();
        put(32'hD1, 0); tick();
        put(32'hD2, 0); tick();
        put(32'hD3, 0); tick();
        check("d_busy", busy, 1);
        check("d_word", word_count, 202);
        put(32'hD4, 1);
        areset = 1'b1; tick();
        areset = 1'b0;
        s.wr_valid = 1'b0;
        check("d_tvalid", s.tvalid, 0);
        check("d_busy_rst", busy, 0);
        check("d_pkt", pkt_count, 0);
        check("d_word_rst", word_count, 0);
        check("d_level", fifo_level, 0);
        check("d_wr_ready", s.wr_ready, 1);
        send(32'hE0, 3, 3, 0);
        drain();
        check("e_pkt", pkt_count, 1);
        check("e_word", word_count, 3);
`else
        pulse_reset();
        s.tready = 1'b1;
        put(32'hF0, 0); tick();
        put(32'hF1, 0); tick();
        put(32'hF2, 0); tick();
        s.wr_valid = 1'b0; tick(); tick();
        check("f_gated", s.tvalid, 0);
        check("f_level", fifo_level, 3);
        put(32'hF3, 1); tick();
        s.wr_valid = 1'b0;
        check("f_gated_last", s.tvalid, 0);
        tick();
        check("f0", {s.tvalid, s.tdata}, {1'b1, 32'hF0});
        tick();
        check("f1", {s.tvalid, s.tdata}, {1'b1, 32'hF1});
        tick();
        check("f2", {s.tvalid, s.tdata}, {1'b1, 32'hF2});
        tick();
        check("f3", {s.tvalid, s.tlast, s.tdata}, {2'b11, 32'hF3});
        tick();
        check("f_done", s.tvalid, 0);
        check("f_word", word_count, 4);
        check("f_no_err", err_oversize, 0);
        send(32'h6000, 20, 20, 0);
        drain();
        check("g_err", err_oversize, 1);
        check("g_word", word_count, 24);
        check("g_pkt", pkt_count, 2);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_stream_tx.md
Name: axi_stream_tx

Overview:
- AXI4-Stream master (transmitter). It is the source-side counterpart of the always-ready stream sinks used in the trading datapath.
- Accepts words from an internal valid/ready write port, buffers them in a synchronous FIFO, and drives tdata/tlast/tvalid into a downstream slave.
- Honours tready backpressure.
- Tracks packet boundaries and exposes status counters for the order-egress path.

Parameters:
- DATA_WIDTH, 32, width of wr_data and tdata (multiple of 8).
- FIFO_DEPTH, 16, buffer entries; power of 2, minimum 4.
- CNT_WIDTH, 32, width of the packet and word counters.

Ports:
- aclk  input  1  single clock for everything.
- areset  input  1  synchronous, active-high reset.
- wr_valid  input  1  write word present.
- wr_ready  output  1  FIFO can accept (not full).
- wr_data  input  DATA_WIDTH  payload word.
- wr_last  input  1  word ends a packet.
- tdata  output  DATA_WIDTH  stream data.
- tkeep  output  DATA_WIDTH/8  byte qualifiers; all ones.
- tlast  output  1  last beat of packet.
- tvalid  output  1  beat valid.
- tready  input  1  downstream accept.
- busy  output  1  high while in state IN_PKT.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  entries held in the FIFO; excludes the output register.
- pkt_count  output  CNT_WIDTH  packets fully transmitted; wraps.
- word_count  output  CNT_WIDTH  beats transmitted; wraps.

Behaviour:
- Reset (synchronous, active-high, sampled on rising aclk):
  - tvalid=0, tdata=0, tlast=0, busy=0, fifo_level=0, pkt_count=0, word_count=0.
  - wr_ready=1 in the cycle after reset deasserts.
  - FIFO pointers cleared; any in-flight beat is dropped.
- Write side:
  - A word is accepted on a rising edge where wr_valid && wr_ready.
  - {wr_last, wr_data} is stored.
  - wr_ready = !full; it is combinational from the FIFO state only, never from wr_valid.
- Output stage:
  - Single register.
  - Loads the FIFO head when (!tvalid || tready) && FIFO non-empty.
  - Otherwise holds its value.
- Latency: a word accepted on edge k has tvalid=1 after edge k+1, given an empty pipe and tready=1. There is no combinational bypass.
- AXI rules:
  - Once tvalid=1, tvalid, tdata and tlast stay stable until the edge where tready=1.
  - tvalid never depends combinationally on tready.
  - A beat is transferred on each edge with tvalid && tready.
- Sustained throughput is 1 beat/cycle: a pop and reload happen on the same edge when tready=1 and the FIFO is non-empty.
- Full boundary:
  - Simultaneous write and pop while full is impossible because wr_ready=0 while full. The pop frees the slot, and wr_ready rises on the next cycle.
  - Simultaneous write and pop at any other level leaves fifo_level unchanged.
- Empty boundary: when tvalid && tready and the FIFO is empty, tvalid drops to 0 on that edge.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.
  - full = MSBs differ and the rest are equal.
  - empty = all bits equal.
- Packet FSM, two states:
  - IDLE -> IN_PKT on a transferred beat with tlast=0.
  - IN_PKT -> IDLE on a transferred beat with tlast=1.
  - A single-beat packet (tlast=1) in IDLE stays in IDLE.
- Counters:
  - word_count increments on every transferred beat.
  - pkt_count increments on each transferred beat with tlast=1.
  - Both wrap from all ones to 0.
- Reset mid-packet:
  - FSM goes to IDLE, all buffered words are lost, counters clear.
  - The downstream device sees tvalid drop without tlast; this is accepted and documented.

Optional Feature:
- Macro: AXI_STREAM_TX_STORE_FWD_EN.
- When defined (store-and-forward mode):
  - A counter tracks complete packets in the FIFO: +1 on a write with wr_last, -1 on popping a tlast word.
  - In IDLE, the output stage loads a word only when that counter > 0. Mid-packet loading is unrestricted.
  - If the FIFO is full and the complete-packet count is 0 (oversize packet), the gate releases for that packet, and a sticky output err_oversize is set. err_oversize is cleared only by reset.
- When undefined: cut-through mode, the err_oversize port is absent, and behaviour is as described above.

Decomposition:
- Package axi_stream_tx_pkg holds:
  - the FSM state enum (IDLE, IN_PKT);
  - a helper function for the FIFO entry width (DATA_WIDTH+1);
  - the pointer-width localparam formula.
- One sub-module: axis_sync_fifo (a parameterised synchronous FIFO with level output). The FSM, output register and counters stay in the top module.

Test Plan:
- Reset then idle -> tvalid=0, wr_ready=1, fifo_level=0, pkt_count=0.
- Write 4 words 0xA0..0xA3 (last on 0xA3) with tready=1 throughout -> beats appear in order at 1 beat/cycle, the first one cycle after acceptance; tlast only on 0xA3; pkt_count=1, word_count=4.
- Hold tready=0 and write 17 words, FIFO_DEPTH=16 -> the output register holds the first word stable, 16 words are in the FIFO, and wr_ready drops after the 17th accepted word. Raise tready -> wr_ready returns 1 cycle after the first pop, and all words arrive without loss.
- Randomly toggle tready over 200 beats -> tdata/tlast never change while tvalid=1 && tready=0, and the scoreboard matches the input order exactly.
- Assert areset for 1 cycle mid-packet, after 2 of 5 beats -> next cycle tvalid=0, busy=0, counters 0, fifo_level=0. A new 3-beat packet then transmits correctly.
- With AXI_STREAM_TX_STORE_FWD_EN: write 3 words without last -> tvalid stays 0. Write the last word -> the 4 beats stream back-to-back. Write a 20-word packet -> err_oversize=1 and all 20 beats still delivered.
